// File: rtl/ram_dual_port_if.sv
// Bus bundle for ram_dual_port: clear/busy control, port A read/write, port B read-only.
// The RAM side uses the slave modport; whoever drives requests uses master.
interface ram_dual_port_if #(
  parameter int WORD_SIZE    = 16,
  parameter int ADDRESS_SIZE = 16
);
  logic                    clear;
  logic                    busy;

  logic                    a_read;
  logic                    a_write;
  logic [ADDRESS_SIZE-1:0] a_address;
  logic [WORD_SIZE-1:0]    a_in_data;
  logic [WORD_SIZE-1:0]    a_out_data;
  logic                    a_out_valid;

  logic                    b_read;
  logic [ADDRESS_SIZE-1:0] b_address;
  logic [WORD_SIZE-1:0]    b_out_data;
  logic                    b_out_valid;

  modport slave (
    input  clear, a_read, a_write, a_address, a_in_data, b_read, b_address,
    output busy, a_out_data, a_out_valid, b_out_data, b_out_valid
  );

  modport master (
    output clear, a_read, a_write, a_address, a_in_data, b_read, b_address,
    input  busy, a_out_data, a_out_valid, b_out_data, b_out_valid
  );
endinterface

// File: rtl/ram_dual_port.sv
// Dual-port RAM: port A read/write, port B read-only, read-first, 1- or 2-cycle read
// latency, with a whole-array clear sweep that locks out both ports while it runs.

// Per-port read return pipe; data only moves with its valid so the output holds between reads.
module ram_dual_port_rd_pipe #(
  parameter int WORD_SIZE = 16,
  parameter int STAGES    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_data,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_data
);
  logic [STAGES:1]                r_vld_pipe;
  logic [STAGES:1][WORD_SIZE-1:0] r_dat_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= i_req;
      if (i_req) r_dat_pipe[1] <= i_data;
      for (int k = 2; k <= STAGES; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
      end
    end
  end

  assign o_valid = r_vld_pipe[STAGES];
  assign o_data  = r_dat_pipe[STAGES];
endmodule

module ram_dual_port #(
  parameter int WORD_SIZE      = 16,
  parameter int ADDRESS_SIZE   = 16,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic           clock,
  input  logic           reset_n,
  ram_dual_port_if.slave bus
);
  localparam int DEPTH     = 1 << ADDRESS_SIZE;
  localparam int NUM_PORTS = 2;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  typedef struct packed {
    logic                    en;
    logic [ADDRESS_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0]    data;
  } wr_req_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDRESS_SIZE-1:0] r_clr_cnt;
  logic                    w_busy;
  logic                    w_sweep_we;
  logic                    w_last;
  wr_req_t                 w_wr;

  logic [WORD_SIZE-1:0]    r_mem [DEPTH];

  logic [NUM_PORTS-1:0]                   w_rd_req;
  logic [NUM_PORTS-1:0][ADDRESS_SIZE-1:0] w_rd_addr;
  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]    w_rd_word;
  logic [NUM_PORTS-1:0][WORD_SIZE-1:0]    w_out_data;
  logic [NUM_PORTS-1:0]                   w_out_valid;

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  assign w_last = (r_clr_cnt == {ADDRESS_SIZE{1'b1}});

  // FSM: next state; a clear request during a sweep does not restart it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.clear) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_last)    w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy     = 1'b0;
    w_sweep_we = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_busy     = 1'b1;
      w_sweep_we = 1'b1;
    end
  end

  // Counter wraps to 0 on the last write, which is also the IDLE-entry value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               r_clr_cnt <= '0;
    else if (r_state == ST_IDLE && bus.clear)   r_clr_cnt <= '0;
    else if (w_sweep_we)                        r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  always_comb begin
    w_wr = '0;
    if (w_sweep_we) begin
      w_wr.en   = 1'b1;
      w_wr.addr = r_clr_cnt;
    end else begin
      w_wr.en   = bus.a_write;
      w_wr.addr = bus.a_address;
      w_wr.data = bus.a_in_data;
    end
  end

  // Array is deliberately not reset; only the sweep zeroes it.
  always_ff @(posedge clock) begin
    if (w_wr.en) r_mem[w_wr.addr] <= w_wr.data;
  end

  assign w_rd_req     = {bus.b_read, bus.a_read} & {NUM_PORTS{~w_busy}};
  assign w_rd_addr[0] = bus.a_address;
  assign w_rd_addr[1] = bus.b_address;

  // Reads sample the array before this edge's write lands: read-first on both ports.
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign w_rd_word[gp] = r_mem[w_rd_addr[gp]];

    ram_dual_port_rd_pipe #(
      .WORD_SIZE (WORD_SIZE),
      .STAGES    (READ_LATENCY)
    ) u_rd_pipe (
      .clock   (clock),
      .reset_n (reset_n),
      .i_req   (w_rd_req[gp]),
      .i_data  (w_rd_word[gp]),
      .o_valid (w_out_valid[gp]),
      .o_data  (w_out_data[gp])
    );
  end

  assign bus.busy        = w_busy;
  assign bus.a_out_data  = w_out_data[0];
  assign bus.a_out_valid = w_out_valid[0];
  assign bus.b_out_data  = w_out_data[1];
  assign bus.b_out_valid = w_out_valid[1];
endmodule

// File: tb/tb_ram_dual_port.sv
// Bench for ram_dual_port: three instances (latency 1, latency 2 sharing stimulus, and
// clear-on-reset), read results scored from per-port expectation queues.
module tb_ram_dual_port;
  localparam int WS = 16;
  localparam int AS = 4;
  localparam int N  = 16;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  ram_dual_port_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) if1 ();
  ram_dual_port_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) if2 ();
  ram_dual_port_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) if3 ();

  ram_dual_port #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .READ_LATENCY(1), .CLEAR_ON_RESET(0))
    dut1 (.clock(clock), .reset_n(rst_n), .bus(if1.slave));
  ram_dual_port #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .READ_LATENCY(2), .CLEAR_ON_RESET(0))
    dut2 (.clock(clock), .reset_n(rst_n), .bus(if2.slave));
  ram_dual_port #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS), .READ_LATENCY(1), .CLEAR_ON_RESET(1))
    dut3 (.clock(clock), .reset_n(rst_n), .bus(if3.slave));

  assign if2.clear     = if1.clear;
  assign if2.a_read    = if1.a_read;
  assign if2.a_write   = if1.a_write;
  assign if2.a_address = if1.a_address;
  assign if2.a_in_data = if1.a_in_data;
  assign if2.b_read    = if1.b_read;
  assign if2.b_address = if1.b_address;

  typedef struct {
    logic [WS-1:0] data;
    int            due;
  } exp_t;

  // streams: 0/1 dut1 A/B, 2/3 dut2 A/B, 4/5 dut3 A/B
  exp_t          q[6][$];
  logic [WS-1:0] last[6];
  logic [WS-1:0] mdl[N];
  logic [WS-1:0] mdl3[N];
  int            cyc    = 0;
  bit            mon_en = 1'b0;
  int            n_chk  = 0;
  int            n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input int s, input logic [WS-1:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.due  = cyc + lat;
    q[s].push_back(e);
  endtask

  task automatic flush();
    for (int s = 0; s < 6; s++) begin
      q[s].delete();
      last[s] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle1();
    if1.clear = 1'b0; if1.a_read = 1'b0; if1.a_write = 1'b0; if1.b_read = 1'b0;
  endtask

  task automatic idle3();
    if3.clear = 1'b0; if3.a_read = 1'b0; if3.a_write = 1'b0; if3.b_read = 1'b0;
  endtask

  // accepted reads on dut1/dut2; expectations captured before any same-edge write updates mdl
  task automatic rd1(input logic [AS-1:0] aa, input bit ae, input logic [AS-1:0] ba, input bit be);
    if1.a_read = ae; if1.b_read = be;
    if (ae) begin if1.a_address = aa; push(0, mdl[aa], 1); push(2, mdl[aa], 2); end
    if (be) begin if1.b_address = ba; push(1, mdl[ba], 1); push(3, mdl[ba], 2); end
  endtask

  task automatic wr1(input logic [AS-1:0] a, input logic [WS-1:0] d);
    if1.a_write = 1'b1; if1.a_address = a; if1.a_in_data = d;
    mdl[a] = d;
  endtask

  task automatic rd3(input logic [AS-1:0] aa, input logic [AS-1:0] ba);
    if3.a_read = 1'b1; if3.a_address = aa; push(4, mdl3[aa], 1);
    if3.b_read = 1'b1; if3.b_address = ba; push(5, mdl3[ba], 1);
  endtask

  always @(negedge clock) begin
    logic          v[6];
    logic [WS-1:0] d[6];
    bit            ev;
    if (mon_en && rst_n) begin
      v[0] = if1.a_out_valid; d[0] = if1.a_out_data;
      v[1] = if1.b_out_valid; d[1] = if1.b_out_data;
      v[2] = if2.a_out_valid; d[2] = if2.a_out_data;
      v[3] = if2.b_out_valid; d[3] = if2.b_out_data;
      v[4] = if3.a_out_valid; d[4] = if3.a_out_data;
      v[5] = if3.b_out_valid; d[5] = if3.b_out_data;
      for (int s = 0; s < 6; s++) begin
        if (q[s].size() > 0 && q[s][0].due < cyc) void'(q[s].pop_front());
        ev = (q[s].size() > 0) && (q[s][0].due == cyc);
        chk($sformatf("valid[%0d]@%0d", s, cyc), 32'(v[s]), 32'(ev));
        if (ev) begin
          chk($sformatf("data[%0d]@%0d", s, cyc), 32'(d[s]), 32'(q[s][0].data));
          last[s] = q[s][0].data;
          void'(q[s].pop_front());
        end else begin
          chk($sformatf("hold[%0d]@%0d", s, cyc), 32'(d[s]), 32'(last[s]));
        end
      end
    end
  end

  initial begin
    idle1(); idle3();
    if1.a_address = '0; if1.b_address = '0; if1.a_in_data = '0;
    if3.a_address = '0; if3.b_address = '0; if3.a_in_data = '0;
    for (int i = 0; i < N; i++) mdl3[i] = '0;
    flush();

    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_data1", 32'(if1.a_out_data), 0);
    chk("rst_a_valid1", 32'(if1.a_out_valid), 0);
    chk("rst_b_valid2", 32'(if2.b_out_valid), 0);
    chk("rst_busy1", 32'(if1.busy), 0);
    chk("rst_busy3", 32'(if3.busy), 1);
    tick(); tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    chk("rel_busy1", 32'(if1.busy), 0);
    chk("rel_busy3", 32'(if3.busy), 1);

    // clear-on-reset sweep: accesses dropped, busy for exactly 16 cycles
    for (int i = 0; i < N; i++) begin
      if3.a_write = 1'b1; if3.a_address = AS'(i); if3.a_in_data = 16'hFFFF;
      if3.a_read = 1'b1; if3.b_read = 1'b1; if3.b_address = AS'(15 - i);
      tick();
      chk($sformatf("cor_busy3[%0d]", i), 32'(if3.busy), 32'(i < 15));
    end
    idle3();

    // write 0x1234 at 3 then read it back
    wr1(4'd3, 16'h1234); tick(); idle1();
    rd1(4'd3, 1'b1, 4'd0, 1'b0); tick(); idle1(); tick(); tick();

    // fill all words nonzero, mem[5] = 0x00AA
    for (int i = 0; i < N; i++) begin
      wr1(AS'(i), (i == 5) ? 16'h00AA : 16'hA000 | 16'(i * 16'h0101));
      tick();
    end
    idle1();

    // read-first on A and cross-port collision on B, then the new word
    rd1(4'd5, 1'b1, 4'd5, 1'b1); wr1(4'd5, 16'h5555); tick(); idle1();
    rd1(4'd5, 1'b1, 4'd5, 1'b1); tick(); idle1(); tick();

    // back-to-back A 0..15, B 15..0
    for (int i = 0; i < N; i++) begin rd1(AS'(i), 1'b1, AS'(15 - i), 1'b1); tick(); end
    idle1(); tick();

    // clear with a read in flight; junk and a repeated clear during the sweep are ignored
    rd1(4'd2, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < N; i++) mdl[i] = '0;
    if1.clear = 1'b1; tick(); idle1();
    chk("clr_busy1_start", 32'(if1.busy), 1);
    chk("clr_busy2_start", 32'(if2.busy), 1);
    for (int i = 0; i < N; i++) begin
      if1.clear = (i == 5); if1.a_write = 1'b1; if1.a_address = 4'd7; if1.a_in_data = 16'hFFFF;
      if1.a_read = 1'b1; if1.b_read = 1'b1; if1.b_address = 4'd7;
      tick();
      chk($sformatf("clr_busy1[%0d]", i), 32'(if1.busy), 32'(i < 15));
    end
    idle1();
    for (int i = 0; i < N; i++) begin rd1(AS'(i), 1'b1, AS'(15 - i), 1'b1); tick(); end
    idle1(); tick(); tick();

    // refill, start a sweep, reset mid-sweep with a dut3 read in flight
    for (int i = 0; i < N; i++) begin
      wr1(AS'(i), 16'hC000 + 16'(i));
      if (i == 0) begin
        if3.a_write = 1'b1; if3.a_address = 4'd9; if3.a_in_data = 16'hBEEF; mdl3[9] = 16'hBEEF;
      end else begin
        if3.a_write = 1'b0;
      end
      tick();
    end
    idle1(); idle3();
    if1.clear = 1'b1; tick(); idle1();
    repeat (3) tick();
    rd3(4'd9, 4'd9); tick(); idle3();
    #1;
    chk("pre_rst_valid3", 32'(if3.a_out_valid), 1);
    chk("pre_rst_data3", 32'(if3.b_out_data), 32'h0000BEEF);
    chk("pre_rst_busy1", 32'(if1.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_data3", 32'(if3.a_out_data), 0);
    chk("mid_rst_a_valid3", 32'(if3.a_out_valid), 0);
    chk("mid_rst_b_data3", 32'(if3.b_out_data), 0);
    chk("mid_rst_b_valid3", 32'(if3.b_out_valid), 0);
    chk("mid_rst_busy1", 32'(if1.busy), 0);
    chk("mid_rst_busy3", 32'(if3.busy), 1);
    flush();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    for (int i = 0; i < N; i++) mdl3[i] = '0;
    tick();
    rst_n = 1'b1;
    chk("rel2_busy3", 32'(if3.busy), 1);

    // partially cleared contents on dut1/dut2 while dut3 restarts its sweep from 0
    for (int i = 0; i < N; i++) begin
      rd1(AS'(i), 1'b1, AS'(15 - i), 1'b1);
      if3.a_read = 1'b1; if3.a_address = 4'd9;
      tick();
      chk($sformatf("rst_sweep_busy3[%0d]", i), 32'(if3.busy), 32'(i < 15));
    end
    idle1(); idle3();
    rd3(4'd9, 4'd0); tick(); idle3();
    repeat (4) tick();
    chk("drain", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size() + q[4].size() + q[5].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
